// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid flags the 4th byte.
import imem_loader_pkg::*;

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] sr;
  logic [1:0]  cnt;

  // Shift each byte in from the top so byte k ends up at bits [8k+7:8k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      sr  <= {in_data, sr[31:8]};
      cnt <= cnt + 2'd1;
    end
  end

  // The completed word is presented combinationally alongside its last byte.
  always_comb begin
    word_valid = in_valid && (cnt == 2'(BYTES_PER_WORD - 1));
    word       = {in_data, sr[31:8]};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length-prefixed byte stream and writes it into
// instruction RAM, holding the core in reset until the image is complete.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned HDR_W = 8 * HDR_BYTES;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [7:0]        hdr_lo;
  logic [HDR_W-1:0]  n_hdr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   word_cnt;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .in_valid   (accept && (state == DATA)),
    .in_data    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the only unregistered output, rx_ready.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    accept     = 1'b0;
    n_hdr      = {rx_data, hdr_lo};
    last_word  = (word_cnt == (len - (ADDR_W+1)'(1)));
    unique case (state)
      IDLE:   state_next = LEN_LO;
      LEN_LO: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (accept) begin
          if (n_hdr == '0)                 state_next = DONE;
          else if (n_hdr > HDR_W'(DEPTH))  state_next = ERR;
          else                             state_next = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (word_valid && last_word) state_next = DONE;
      end
      DONE, ERR: if (load) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Header capture, word counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= word_valid;
      if (word_valid) begin
        imem_wdata <= word;
        imem_waddr <= word_cnt[ADDR_W-1:0];
        word_cnt   <= word_cnt + (ADDR_W+1)'(1);
      end
      if (state == IDLE) word_cnt <= '0;
      if (state == LEN_LO && accept) hdr_lo <= rx_data;
      // Truncation is safe: oversize lengths divert to ERR and never use len.
      if (state == LEN_HI && accept) len <= n_hdr[ADDR_W:0];
      error <= (state_next == ERR);
      // DONE is entered on the edge that launches the final write, so dropping
      // hold one edge later lets that write land before the core runs.
      cpu_hold <= !((state == DONE) && !load);
      done     <= (state == DONE) && cpu_hold && !load;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              load;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load       (load),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  int          wr_base;
  logic [31:0] last_addr = '0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the next expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_wr++;
      last_addr = 32'(imem_waddr);
      if (exp_addr.size() == 0) begin
        chk("unexpected_we", {31'b0, imem_we}, 32'd0);
      end else begin
        chk("waddr", 32'(imem_waddr), exp_addr.pop_front());
        chk("wdata", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input bit bp);
    bit acc;
    int guard;
    guard = 0;
    if (bp && ($urandom_range(0, 1) == 0)) begin
      rx_valid = 1'b0;
      cyc();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      acc = rx_ready;
      cyc();
      guard++;
    end while (!acc && guard < 20);
    if (!acc) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
  endtask

  task automatic put_bytes(input logic [7:0] q[$], input bit bp);
    foreach (q[i]) put(q[i], bp);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (!done && k < lim) begin
      cyc();
      k++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; load = 1'b0;

    // Reset values.
    repeat (3) cyc();
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst_we",       {31'b0, imem_we},  32'd0);
    chk("rst_waddr",    32'(imem_waddr),   32'd0);
    chk("rst_wdata",    imem_wdata,        32'd0);
    chk("rst_hold",     {31'b0, cpu_hold}, 32'd1);
    chk("rst_done",     {31'b0, done},     32'd0);
    chk("rst_error",    {31'b0, error},    32'd0);
    rst = 1'b0;
    chk("rel_rx_ready0", {31'b0, rx_ready}, 32'd0);
    cyc();
    chk("rel_rx_ready1", {31'b0, rx_ready}, 32'd1);

    // Two-word image, gap-free.
    exp_addr.push_back(32'd0); exp_data.push_back(32'h0000_0013);
    exp_addr.push_back(32'd1); exp_data.push_back(32'h0010_0093);
    bytes = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    put_bytes(bytes, 1'b0);
    chk("w2_last_we",  {31'b0, imem_we},  32'd1);
    chk("w2_hold_hi",  {31'b0, cpu_hold}, 32'd1);
    chk("w2_done_lo",  {31'b0, done},     32'd0);
    cyc();
    chk("w2_hold_lo",  {31'b0, cpu_hold}, 32'd0);
    chk("w2_done_hi",  {31'b0, done},     32'd1);
    chk("w2_we_off",   {31'b0, imem_we},  32'd0);
    chk("w2_nwr",      32'(n_wr),         32'd2);
    cyc();
    chk("w2_done_1cy", {31'b0, done},     32'd0);

    // Reload re-asserts hold on the same edge.
    pulse_load();
    chk("ld_hold",     {31'b0, cpu_hold}, 32'd1);
    chk("ld_rx_ready", {31'b0, rx_ready}, 32'd0);
    cyc();
    chk("ld_rx_ready1", {31'b0, rx_ready}, 32'd1);

    // Zero-length image.
    wr_base = n_wr;
    bytes = '{8'h00, 8'h00};
    put_bytes(bytes, 1'b0);
    chk("n0_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("n0_hold_hi",  {31'b0, cpu_hold}, 32'd1);
    cyc();
    chk("n0_hold_lo",  {31'b0, cpu_hold}, 32'd0);
    chk("n0_done",     {31'b0, done},     32'd1);
    chk("n0_nwr",      32'(n_wr - wr_base), 32'd0);
    pulse_load();

    // Oversize header (N = 1025).
    bytes = '{8'h01, 8'h04};
    put_bytes(bytes, 1'b0);
    chk("ov_error",    {31'b0, error},    32'd1);
    chk("ov_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("ov_hold",     {31'b0, cpu_hold}, 32'd1);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) cyc();
    rx_valid = 1'b0;
    chk("ov_sticky",   {31'b0, error},    32'd1);
    chk("ov_rdy_stay", {31'b0, rx_ready}, 32'd0);
    chk("ov_nwr",      32'(n_wr - wr_base), 32'd0);
    pulse_load();
    chk("ov_clear",    {31'b0, error},    32'd0);
    cyc();
    chk("ov_accept",   {31'b0, rx_ready}, 32'd1);

    // Full depth with random bubbles.
    wr_base = n_wr;
    bytes.delete();
    bytes.push_back(8'h00);
    bytes.push_back(8'h04);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'(i) * 32'h0101_0101;
      exp_addr.push_back(32'(i));
      exp_data.push_back(w);
      for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
    end
    put_bytes(bytes, 1'b1);
    wait_done(10);
    chk("fd_nwr",      32'(n_wr - wr_base), 32'd1024);
    chk("fd_last",     last_addr,           32'h3FF);
    chk("fd_pending",  32'(exp_addr.size()), 32'd0);
    repeat (5) cyc();
    chk("fd_no_wrap",  32'(n_wr - wr_base), 32'd1024);
    chk("fd_hold",     {31'b0, cpu_hold},   32'd0);
    pulse_load();

    // Reset mid-word.
    wr_base = n_wr;
    bytes = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    put_bytes(bytes, 1'b0);
    rst = 1'b1;
    #1;
    chk("mr_we",       {31'b0, imem_we},  32'd0);
    chk("mr_hold",     {31'b0, cpu_hold}, 32'd1);
    chk("mr_rx_ready", {31'b0, rx_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    chk("mr_nwr",      32'(n_wr - wr_base), 32'd0);
    exp_addr.push_back(32'd0); exp_data.push_back(32'hDEAD_BEEF);
    bytes = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    put_bytes(bytes, 1'b0);
    wait_done(10);
    chk("mr_fresh_nwr", 32'(n_wr - wr_base), 32'd1);

    // Reload overwrites address 0.
    cyc();
    pulse_load();
    chk("rl_hold",     {31'b0, cpu_hold}, 32'd1);
    wr_base = n_wr;
    exp_addr.push_back(32'd0); exp_data.push_back(32'h1234_5678);
    bytes = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    put_bytes(bytes, 1'b0);
    wait_done(10);
    chk("rl_nwr",      32'(n_wr - wr_base), 32'd1);
    chk("rl_pending",  32'(exp_addr.size()), 32'd0);
    chk("rl_hold_lo",  {31'b0, cpu_hold}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
